multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Multi-cycle MIPS controller. Sequences a shared-memory datapath (PC, IR, A/B, ALUOut, MDR) through
//  FETCH/DECODE/EXECUTE/MEM/WB for R-type (add/sub/and/or/slt), lw, sw, beq, j and addi.
//  Handles a variable-latency memory through a ready handshake, with a timeout.
//  Replaces the single-cycle decoder for the multi-cycle core variant.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max consecutive wait cycles in one memory state before abort (>=2)
//  CNT_W           5   width of the wait counter; must hold TIMEOUT_CYCLES-1
// PORTS
//  clk            in   1  rising-edge clock
//  rst_n          in   1  asynchronous active-low reset
//  opcode         in   6  IR[31:26]; sampled only in DECODE
//  funct          in   6  IR[5:0]; sampled only in DECODE/EXECUTE
//  mem_ready      in   1  memory completes current read/write this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (beq)
//  pc_source      out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
//  i_or_d         out  1  memory address: 0 PC, 1 ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  IR load
//  reg_dst        out  1  write-register select: 0 rt, 1 rd
//  mem_to_reg     out  1  write-data select: 0 ALUOut, 1 MDR
//  reg_write      out  1  register-file write enable
//  alu_src_a      out  1  0 PC, 1 A
//  alu_src_b      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  alu_control    out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
//  instr_retired  out  1  one-cycle pulse on the final cycle of each completed instruction
//  illegal_op     out  1  one-cycle pulse: unsupported opcode, or unsupported funct on R-type
//  mem_error      out  1  one-cycle pulse: memory timeout abort
//  state_o        out  4  current state encoding, for debug
// BEHAVIOUR
//  - Outputs are decoded combinationally from the state register, plus mem_ready where noted.
//  - While rst_n=0: state=FETCH, wait counter=0, all outputs 0. After release, FETCH.
//  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ADD, pc_source=00.
//    - ir_write=pc_write=mem_ready.
//    - Next state: DECODE if mem_ready, else stay in FETCH.
//  - DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
//    - 000000 -> EXECUTE.
//    - 100011/101011 -> MEM_ADDR.
//    - 000100 -> BRANCH.
//    - 000010 -> JUMP.
//    - 001000 -> ADDI_EX.
//    - Any other opcode, or R-type with funct outside {100000,100010,100100,100101,101010}:
//      illegal_op=1, -> FETCH. Nothing is written.
//  - MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. -> MEM_READ (lw) or MEM_WRITE (sw).
//  - MEM_READ: mem_read=1, i_or_d=1. -> MEM_WB on mem_ready.
//  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_retired=1. -> FETCH.
//  - MEM_WRITE: mem_write=1, i_or_d=1. On mem_ready: instr_retired=1, -> FETCH.
//  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct. -> R_WB.
//  - R_WB: reg_dst=1, reg_write=1, mem_to_reg=0, alu_control held from funct, instr_retired=1. -> FETCH.
//  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01, instr_retired=1. -> FETCH.
//  - JUMP: pc_write=1, pc_source=10, instr_retired=1. -> FETCH.
//  - ADDI_EX: alu_src_a=1, alu_src_b=10, ADD. -> ADDI_WB.
//  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_retired=1. -> FETCH.
//  - Latency with zero-wait memory (mem_ready=1 throughout), in cycles:
//    R 4, lw 5, sw 4, beq 3, j 3, addi 4. Each wait cycle adds 1.
//  - Wait counter:
//    - Increments each cycle in FETCH/MEM_READ/MEM_WRITE while mem_ready=0.
//    - Clears on any state change or when mem_ready=1.
//  - Timeout:
//    - Triggers when the counter equals TIMEOUT_CYCLES-1 and mem_ready=0.
//    - Response: mem_error=1, no write/load enable asserted, counter cleared, -> FETCH (PC unchanged).
//    - If mem_ready=1 in the same cycle as the limit, the transfer completes normally and no error is raised.
//  - Reset asserted mid-instruction: immediate return to FETCH with all outputs 0.
//    A partially completed instruction is not retired.
//  - Unused state encodings: all outputs 0, -> FETCH.
// TESTING
//  1. Zero-wait add (op 000000, funct 100000): states F,D,EX,RWB.
//     - reg_write=1 and reg_dst=1 only in cycle 4.
//     - instr_retired=1 in cycle 4.
//  2. lw with mem_ready low 3 cycles in MEM_READ: total 8 cycles.
//     - mem_read held high in MEM_READ.
//     - MEM_WB asserts mem_to_reg=1 and reg_write=1.
//  3. beq (000100): cycle 3 has pc_write_cond=1, pc_source=01, alu_control=0110, instr_retired=1.
//     - j (000010): cycle 3 has pc_write=1, pc_source=10.
//  4. opcode 111111 at DECODE:
//     - illegal_op pulses once, then next state FETCH.
//     - No reg_write or mem_write at any point.
//  5. TIMEOUT_CYCLES=16, mem_ready held 0 in MEM_WRITE:
//     - mem_error pulses on the 16th wait cycle, then FETCH; no instr_retired.
//     - Repeat with mem_ready=1 on that same cycle: retired, no mem_error.
//  6. rst_n pulsed low during EXECUTE:
//     - All outputs 0 asynchronously, state_o=FETCH.
//     - FETCH resumes with mem_read=1 after release.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle controller and its datapath/memory.
// The controller takes the master side; the datapath takes the slave side.
interface multicycle_control_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
    logic       instr_retired;
    logic       illegal_op;
    logic       mem_error;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_control, instr_retired, illegal_op, mem_error, state_o
    );

    modport slave (
        output opcode, funct, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_control, instr_retired, illegal_op, mem_error, state_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS controller: sequences FETCH/DECODE/EXECUTE/MEM/WB with a
// variable-latency memory handshake and a wait-cycle timeout.
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       instr_retired;
        logic       illegal_op;
        logic       mem_error;
        logic [3:0] state_o;
    } ctrl_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_store;
    logic             is_store_next;
    logic [3:0]       alu_funct;
    logic [3:0]       alu_funct_next;
    logic             wait_state;
    logic             timeout;
    logic [4:0]       funct_dec;
    ctrl_t            ctrl;

    // {valid, alu_control} for the supported R-type functions
    function automatic logic [4:0] decode_funct(input logic [5:0] f);
        logic [4:0] res;
        case (f)
            6'b100000: res = {1'b1, ALU_ADD};
            6'b100010: res = {1'b1, ALU_SUB};
            6'b100100: res = {1'b1, ALU_AND};
            6'b100101: res = {1'b1, ALU_OR};
            6'b101010: res = {1'b1, ALU_SLT};
            default:   res = 5'b0;
        endcase
        return res;
    endfunction

    assign funct_dec  = decode_funct(bus.funct);
    assign wait_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign timeout    = wait_state && !bus.mem_ready && (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            is_store  <= 1'b0;
            alu_funct <= ALU_ADD;
        end else begin
            state     <= state_next;
            is_store  <= is_store_next;
            alu_funct <= alu_funct_next;
            if (wait_state && !bus.mem_ready && !timeout && (state_next == state))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        ctrl           = '0;
        ctrl.state_o   = state;
        state_next     = state;
        is_store_next  = is_store;
        alu_funct_next = alu_funct;
        case (state)
            S_FETCH: begin
                ctrl.mem_read    = 1'b1;
                ctrl.alu_src_b   = 2'b01;
                ctrl.alu_control = ALU_ADD;
                ctrl.ir_write    = bus.mem_ready;
                ctrl.pc_write    = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    ctrl.mem_error = 1'b1;
                    state_next     = S_FETCH;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b   = 2'b11;
                ctrl.alu_control = ALU_ADD;
                state_next       = S_FETCH;
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (funct_dec[4]) begin
                            state_next     = S_EXECUTE;
                            alu_funct_next = funct_dec[3:0];
                        end else begin
                            ctrl.illegal_op = 1'b1;
                        end
                    end
                    OP_LW: begin
                        state_next    = S_MEM_ADDR;
                        is_store_next = 1'b0;
                    end
                    OP_SW: begin
                        state_next    = S_MEM_ADDR;
                        is_store_next = 1'b1;
                    end
                    OP_BEQ:  state_next = S_BRANCH;
                    OP_J:    state_next = S_JUMP;
                    OP_ADDI: state_next = S_ADDI_EX;
                    default: ctrl.illegal_op = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = 2'b10;
                ctrl.alu_control = ALU_ADD;
                state_next       = is_store ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout) begin
                    ctrl.mem_error = 1'b1;
                    state_next     = S_FETCH;
                end
            end
            S_MEM_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.mem_to_reg    = 1'b1;
                ctrl.instr_retired = 1'b1;
                state_next         = S_FETCH;
            end
            S_MEM_WRITE: begin
                // The write strobe is withdrawn on the abort cycle so nothing lands in memory
                ctrl.mem_write = !timeout;
                ctrl.i_or_d    = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.instr_retired = 1'b1;
                    state_next         = S_FETCH;
                end else if (timeout) begin
                    ctrl.mem_error = 1'b1;
                    state_next     = S_FETCH;
                end
            end
            S_EXECUTE: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_control = alu_funct;
                state_next       = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_dst       = 1'b1;
                ctrl.reg_write     = 1'b1;
                ctrl.alu_control   = alu_funct;
                ctrl.instr_retired = 1'b1;
                state_next         = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_control   = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
                ctrl.instr_retired = 1'b1;
                state_next         = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write      = 1'b1;
                ctrl.pc_source     = 2'b10;
                ctrl.instr_retired = 1'b1;
                state_next         = S_FETCH;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = 2'b10;
                ctrl.alu_control = ALU_ADD;
                state_next       = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.instr_retired = 1'b1;
                state_next         = S_FETCH;
            end
            default: begin
                ctrl.state_o = state;
                state_next   = S_FETCH;
            end
        endcase
        // Reset forces every output low without waiting for a clock edge
        if (!rst_n) ctrl = '0;
    end

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_control   = ctrl.alu_control;
    assign bus.instr_retired = ctrl.instr_retired;
    assign bus.illegal_op    = ctrl.illegal_op;
    assign bus.mem_error     = ctrl.mem_error;
    assign bus.state_o       = ctrl.state_o;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for the multi-cycle controller: each queued entry carries the
// inputs for one cycle and the full control word expected in that cycle.
module tb_multicycle_control_fsm;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       instr_retired;
        logic       illegal_op;
        logic       mem_error;
        logic [3:0] state;
    } ctrl_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       mr;
        ctrl_t      exp;
    } entry_t;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
    localparam logic [3:0] EX = 4'd6, RWB = 4'd7, BR = 4'd8, JP = 4'd9, AEX = 4'd10, AWB = 4'd11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [5:0] cur_op = '0;
    logic [5:0] cur_fn = '0;
    entry_t     sb_q[$];

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic ctrl_t sample();
        ctrl_t c;
        c = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
             bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
             bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.instr_retired,
             bus.illegal_op, bus.mem_error, bus.state_o};
        return c;
    endfunction

    // Reference control word for each state, written from the state descriptions
    function automatic ctrl_t st_ctrl(input logic [3:0] st, input logic [3:0] alu, input logic mr);
        ctrl_t c;
        c = '0;
        c.state = st;
        case (st)
            F:   begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_control = 4'b0010;
                       c.ir_write = mr; c.pc_write = mr; end
            D:   begin c.alu_src_b = 2'b11; c.alu_control = 4'b0010; end
            MA:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = 4'b0010; end
            MR:  begin c.mem_read = 1; c.i_or_d = 1; end
            MWB: begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_retired = 1; end
            MW:  begin c.mem_write = 1; c.i_or_d = 1; c.instr_retired = mr; end
            EX:  begin c.alu_src_a = 1; c.alu_src_b = 2'b00; c.alu_control = alu; end
            RWB: begin c.reg_dst = 1; c.reg_write = 1; c.alu_control = alu; c.instr_retired = 1; end
            BR:  begin c.alu_src_a = 1; c.alu_control = 4'b0110; c.pc_write_cond = 1;
                       c.pc_source = 2'b01; c.instr_retired = 1; end
            JP:  begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_retired = 1; end
            AEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_control = 4'b0010; end
            AWB: begin c.reg_write = 1; c.instr_retired = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic push(input string name, input logic mr, input ctrl_t e);
        entry_t ent;
        ent.name = name;
        ent.op   = cur_op;
        ent.fn   = cur_fn;
        ent.mr   = mr;
        ent.exp  = e;
        sb_q.push_back(ent);
    endtask

    task automatic push_state(input string name, input logic [3:0] st, input logic [3:0] alu, input logic mr);
        push(name, mr, st_ctrl(st, alu, mr));
    endtask

    task automatic push_rtype(input string name, input logic [5:0] fn, input logic [3:0] alu);
        cur_op = 6'b000000;
        cur_fn = fn;
        push_state({name, "_fetch"}, F, 4'b0, 1'b1);
        push_state({name, "_decode"}, D, 4'b0, 1'b1);
        push_state({name, "_exec"}, EX, alu, 1'b1);
        push_state({name, "_rwb"}, RWB, alu, 1'b1);
    endtask

    task automatic test_reset();
        ctrl_t got;
        rst_n = 1'b0;
        bus.opcode = '0;
        bus.funct = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got = sample();
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: got %h expected %h", got, ctrl_t'('0));
        end
        bus.mem_ready = 1'b1;
        #1;
        got = sample();
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_ready_high: got %h expected %h", got, ctrl_t'('0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        entry_t ent;
        ctrl_t  got;
        push_rtype("add", 6'b100000, 4'b0010);
        while (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            bus.opcode = ent.op; bus.funct = ent.fn; bus.mem_ready = ent.mr;
            @(negedge clk);
            got = sample();
            n_checks++;
            if (got !== ent.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected %h", ent.name, got, ent.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype_ops();
        entry_t ent;
        ctrl_t  got;
        push_rtype("sub", 6'b100010, 4'b0110);
        push_rtype("and", 6'b100100, 4'b0000);
        push_rtype("or",  6'b100101, 4'b0001);
        push_rtype("slt", 6'b101010, 4'b0111);
        while (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            bus.opcode = ent.op; bus.funct = ent.fn; bus.mem_ready = ent.mr;
            @(negedge clk);
            got = sample();
            n_checks++;
            if (got !== ent.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected %h", ent.name, got, ent.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_access();
        entry_t ent;
        ctrl_t  got;
        // lw with three wait cycles in MEM_READ: eight cycles in total
        cur_op = 6'b100011; cur_fn = 6'b000000;
        push_state("lw_fetch", F, 4'b0, 1'b1);
        push_state("lw_decode", D, 4'b0, 1'b1);
        push_state("lw_addr", MA, 4'b0, 1'b1);
        for (int i = 0; i < 3; i++) push_state("lw_read_wait", MR, 4'b0, 1'b0);
        push_state("lw_read_done", MR, 4'b0, 1'b1);
        push_state("lw_wb", MWB, 4'b0, 1'b1);
        // sw with one fetch wait and a single MEM_WRITE wait
        cur_op = 6'b101011;
        push_state("sw_fetch_wait", F, 4'b0, 1'b0);
        push_state("sw_fetch", F, 4'b0, 1'b1);
        push_state("sw_decode", D, 4'b0, 1'b1);
        push_state("sw_addr", MA, 4'b0, 1'b1);
        push_state("sw_write_wait", MW, 4'b0, 1'b0);
        push_state("sw_write_done", MW, 4'b0, 1'b1);
        while (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            bus.opcode = ent.op; bus.funct = ent.fn; bus.mem_ready = ent.mr;
            @(negedge clk);
            got = sample();
            n_checks++;
            if (got !== ent.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected %h", ent.name, got, ent.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump_addi();
        entry_t ent;
        ctrl_t  got;
        cur_op = 6'b000100; cur_fn = 6'b000000;
        push_state("beq_fetch", F, 4'b0, 1'b1);
        push_state("beq_decode", D, 4'b0, 1'b1);
        push_state("beq_branch", BR, 4'b0, 1'b1);
        cur_op = 6'b000010;
        push_state("j_fetch", F, 4'b0, 1'b1);
        push_state("j_decode", D, 4'b0, 1'b1);
        push_state("j_jump", JP, 4'b0, 1'b1);
        cur_op = 6'b001000;
        push_state("addi_fetch", F, 4'b0, 1'b1);
        push_state("addi_decode", D, 4'b0, 1'b1);
        push_state("addi_exec", AEX, 4'b0, 1'b1);
        push_state("addi_wb", AWB, 4'b0, 1'b1);
        while (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            bus.opcode = ent.op; bus.funct = ent.fn; bus.mem_ready = ent.mr;
            @(negedge clk);
            got = sample();
            n_checks++;
            if (got !== ent.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected %h", ent.name, got, ent.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        entry_t ent;
        ctrl_t  got;
        ctrl_t  e;
        e = st_ctrl(D, 4'b0, 1'b1);
        e.illegal_op = 1'b1;
        cur_op = 6'b111111; cur_fn = 6'b100000;
        push_state("badop_fetch", F, 4'b0, 1'b1);
        push("badop_decode", 1'b1, e);
        cur_op = 6'b000000; cur_fn = 6'b000001;
        push_state("badfunct_fetch", F, 4'b0, 1'b1);
        push("badfunct_decode", 1'b1, e);
        cur_op = 6'b000100; cur_fn = 6'b000000;
        push_state("after_illegal_fetch", F, 4'b0, 1'b1);
        push_state("after_illegal_decode", D, 4'b0, 1'b1);
        push_state("after_illegal_branch", BR, 4'b0, 1'b1);
        while (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            bus.opcode = ent.op; bus.funct = ent.fn; bus.mem_ready = ent.mr;
            @(negedge clk);
            got = sample();
            n_checks++;
            if (got !== ent.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected %h", ent.name, got, ent.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        entry_t ent;
        ctrl_t  got;
        ctrl_t  e;
        cur_op = 6'b101011; cur_fn = 6'b000000;
        push_state("to_sw_fetch", F, 4'b0, 1'b1);
        push_state("to_sw_decode", D, 4'b0, 1'b1);
        push_state("to_sw_addr", MA, 4'b0, 1'b1);
        for (int i = 0; i < 15; i++) push_state("to_sw_wait", MW, 4'b0, 1'b0);
        e = st_ctrl(MW, 4'b0, 1'b0);
        e.mem_error = 1'b1;
        e.mem_write = 1'b0;
        push("to_sw_abort", 1'b0, e);
        // Ready arriving on the limit cycle completes the store normally
        push_state("lim_sw_fetch", F, 4'b0, 1'b1);
        push_state("lim_sw_decode", D, 4'b0, 1'b1);
        push_state("lim_sw_addr", MA, 4'b0, 1'b1);
        for (int i = 0; i < 15; i++) push_state("lim_sw_wait", MW, 4'b0, 1'b0);
        push_state("lim_sw_done", MW, 4'b0, 1'b1);
        for (int i = 0; i < 15; i++) push_state("to_fetch_wait", F, 4'b0, 1'b0);
        e = st_ctrl(F, 4'b0, 1'b0);
        e.mem_error = 1'b1;
        push("to_fetch_abort", 1'b0, e);
        push_state("to_fetch_retry", F, 4'b0, 1'b1);
        push_state("to_fetch_decode", D, 4'b0, 1'b1);
        push_state("to_fetch_addr", MA, 4'b0, 1'b1);
        push_state("to_fetch_store", MW, 4'b0, 1'b1);
        while (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            bus.opcode = ent.op; bus.funct = ent.fn; bus.mem_ready = ent.mr;
            @(negedge clk);
            got = sample();
            n_checks++;
            if (got !== ent.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected %h", ent.name, got, ent.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        entry_t ent;
        ctrl_t  got;
        cur_op = 6'b100011; cur_fn = 6'b000000;
        push_state("b2b_lw_fetch", F, 4'b0, 1'b1);
        push_state("b2b_lw_decode", D, 4'b0, 1'b1);
        push_state("b2b_lw_addr", MA, 4'b0, 1'b1);
        push_state("b2b_lw_read", MR, 4'b0, 1'b1);
        push_state("b2b_lw_wb", MWB, 4'b0, 1'b1);
        push_rtype("b2b_slt", 6'b101010, 4'b0111);
        cur_op = 6'b000010; cur_fn = 6'b000000;
        push_state("b2b_j_fetch", F, 4'b0, 1'b1);
        push_state("b2b_j_decode", D, 4'b0, 1'b1);
        push_state("b2b_j_jump", JP, 4'b0, 1'b1);
        while (sb_q.size() != 0) begin
            ent = sb_q.pop_front();
            bus.opcode = ent.op; bus.funct = ent.fn; bus.mem_ready = ent.mr;
            @(negedge clk);
            got = sample();
            n_checks++;
            if (got !== ent.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h expected %h", ent.name, got, ent.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        entry_t ent;
        ctrl_t  got;
        cur_op = 6'b000000; cur_fn = 6'b100010;
        push_state("mid_fetch", F, 4'b0, 1'b1);
        push_state("mid_decode", D, 4'b0, 1'b1);
        push_state("mid_exec", EX, 4'b0110, 1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            while (sb_q.size() != 0) begin
                ent = sb_q.pop_front();
                bus.opcode = ent.op; bus.funct = ent.fn; bus.mem_ready = ent.mr;
                @(negedge clk);
                got = sample();
                n_checks++;
                if (got !== ent.exp) begin
                    n_fail++;
                    $display("[TB] FAIL %s: got %h expected %h", ent.name, got, ent.exp);
                end
                if (pass == 0 && sb_q.size() == 0) begin
                    // Still inside EXECUTE: drop reset with no clock edge in between
                    rst_n = 1'b0;
                    #1;
                    got = sample();
                    n_checks++;
                    if (got !== '0) begin
                        n_fail++;
                        $display("[TB] FAIL mid_reset_async: got %h expected %h", got, ctrl_t'('0));
                    end
                    bus.mem_ready = 1'b0;
                    @(posedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                end
                @(posedge clk); #1;
            end
            if (pass == 0) push_rtype("mid_resume", 6'b100010, 4'b0110);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_rtype_ops();
        test_mem_access();
        test_branch_jump_addi();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
